// File: rtl/out_port_pkg.sv
// Shared types and defaults for the output-port UART.
package out_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DEFAULT_CLKS_PER_BIT = 16;
  localparam int   DEFAULT_DEPTH        = 4;
  localparam logic UART_IDLE_LEVEL      = 1'b1;

  // Line level that a given frame state drives; data_bit is only used in DATA.
  function automatic logic tx_level(input tx_state_t state, input logic data_bit);
    case (state)
      START:   return 1'b0;
      DATA:    return data_bit;
      default: return UART_IDLE_LEVEL;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with registered full/empty flags and a live count.
module sync_fifo
  import out_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still legal when the head leaves on the same edge.
  assign do_push = push && (!full_reg || pop);
  assign do_pop  = pop && !empty_reg;

  // Head is presented directly; the consumer registers it when it pops.
  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;

  // Occupancy after this edge; push and pop together cancel.
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

endmodule

// File: rtl/out_port_uart.sv
// CPU output port: captures alu_out on the output strobe, keeps the last byte
// visible on data_out, and serialises buffered bytes as 8N1 UART frames.
module out_port_uart
  import out_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DEPTH        = DEFAULT_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int            TW       = $clog2(CLKS_PER_BIT);
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  tx_state_t     state_reg;
  tx_state_t     state_next;
  logic [TW-1:0] timer_reg;
  logic [TW-1:0] timer_next;
  logic [2:0]    bit_idx_reg;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift_reg;
  logic [7:0]    shift_next;
  logic          tx_reg;
  logic          tx_next;
  logic          busy_reg;
  logic          busy_next;
  logic [7:0]    data_out_reg;
  logic          overflow_reg;

  logic          pop;
  logic          accept;
  logic          bit_done;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  // A pop on this edge frees a slot, so a write into a full FIFO still lands.
  assign accept   = write_en && ((fifo_count != CW'(DEPTH)) || pop);
  assign bit_done = (timer_reg == BIT_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Last accepted byte and the sticky dropped-write flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_reg <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      if (accept) begin
        data_out_reg <= data_in;
      end else if (write_en) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Frame sequencing; tx and busy are derived from the next state so they are
  // registered alongside the FSM with no path from write_en.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg + TW'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = fifo_head;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_next   = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_next = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        timer_next = '0;
        state_next = IDLE;
      end
    endcase
    tx_next   = tx_level(state_next, shift_next[0]);
    busy_next = (state_next != IDLE);
  end

  // FSM and line registers; reset aborts any frame and drives the line idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      tx_reg      <= UART_IDLE_LEVEL;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
    end
  end

  assign data_out = data_out_reg;
  assign overflow = overflow_reg;
  assign tx       = tx_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_out_port_uart.sv
// Bench for out_port_uart: cycle-level frame model plus directed scenarios.
module tb_out_port_uart;

  localparam int CPB = 4;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write_en = 1'b1;
  logic [7:0] data_in = 8'hFF;
  logic [7:0] data_out;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  // Model state: pending bytes, position within current frame (-1 idle).
  logic [7:0] m_q[$];
  logic [7:0] sent_q[$];
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_dout = 8'h00;
  logic       m_ovf = 1'b0;
  int         cycle = 0;

  always #5 clk = ~clk;

  out_port_uart #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // Line level from the 8N1 frame layout: start, 8 data LSB first, stop.
  function automatic logic exp_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  task automatic model_step();
    if (!rst) begin
      m_q.delete();
      m_pos  = -1;
      m_ovf  = 1'b0;
      m_dout = 8'h00;
    end else begin
      if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == 10 * CPB) m_pos = -1;
      end else if (m_q.size() > 0) begin
        m_byte = m_q.pop_front();
        sent_q.push_back(m_byte);
        m_pos = 0;
      end
      if (write_en) begin
        if (m_q.size() < DEP) begin
          m_q.push_back(data_in);
          m_dout = data_in;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      cycle++;
      @(negedge clk);
      vectors++;
      if ({tx, busy, empty, full, overflow, data_out} !==
          {exp_tx(), (m_pos >= 0), (m_q.size() == 0), (m_q.size() == DEP), m_ovf, m_dout}) begin
        miscompares++;
        $display("FAIL cycle %0d: tx/busy/empty/full/ovf/dout got %b%b%b%b%b/%h want %b%b%b%b%b/%h",
                 cycle, tx, busy, empty, full, overflow, data_out,
                 exp_tx(), (m_pos >= 0), (m_q.size() == 0), (m_q.size() == DEP), m_ovf, m_dout);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Inputs change 1ns after an edge and are sampled by the following edge.
  task automatic drive(input logic r, input logic we, input logic [7:0] d);
    @(posedge clk);
    #1;
    rst      = r;
    write_en = we;
    data_in  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 8'h00);
  endtask

  logic [9:0] fr;
  logic [7:0] exp_stream [17];

  initial begin
    exp_stream = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                   8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h77, 8'h5A, 8'hC3};

    // Reset held two edges while a write is attempted.
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("reset_tx", {7'd0, tx}, 8'h01);
    check("reset_data_out", data_out, 8'h00);
    check("reset_empty", {7'd0, empty}, 8'h01);
    check("reset_overflow", {7'd0, overflow}, 8'h00);
    check("reset_busy", {7'd0, busy}, 8'h00);

    // Single write of 0xA5; walk the whole frame edge by edge.
    drive(1'b1, 1'b1, 8'hA5);
    drive(1'b1, 1'b0, 8'h00);
    fr = 10'b1_1010_0101_0;
    @(negedge clk);
    check("a5_data_out", data_out, 8'hA5);
    check("a5_pre_tx", {7'd0, tx}, 8'h01);
    check("a5_pre_empty", {7'd0, empty}, 8'h00);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 40) begin
        check($sformatf("a5_tx_k%0d", k), {7'd0, tx}, {7'd0, fr[(k-1)/CPB]});
      end
      if (k == 1 || k == 40 || k == 41) begin
        check($sformatf("a5_busy_k%0d", k), {7'd0, busy}, (k == 41) ? 8'h00 : 8'h01);
      end
    end
    check("a5_post_empty", {7'd0, empty}, 8'h01);

    // Back-to-back writes.
    drive(1'b1, 1'b1, 8'h01);
    drive(1'b1, 1'b1, 8'h02);
    drive(1'b1, 1'b1, 8'h03);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("b2b_data_out", data_out, 8'h03);
    idle(3 * 41 + 5);

    // Six writes with the transmitter idle: the sixth is dropped.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'h10 + 8'(i));
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("ovf_flag", {7'd0, overflow}, 8'h01);
    check("ovf_data_out", data_out, 8'h14);
    check("ovf_full", {7'd0, full}, 8'h01);
    idle(5 * 41 + 5);
    check("ovf_sticky", {7'd0, overflow}, 8'h01);
    check("ovf_drained", {7'd0, empty}, 8'h01);

    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("rst2_overflow", {7'd0, overflow}, 8'h00);

    // Fill while framing, then write exactly on the pop edge after STOP.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'h20 + 8'(i));
    repeat (37) drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("pop_wr_full", {7'd0, full}, 8'h01);
    check("pop_wr_overflow", {7'd0, overflow}, 8'h00);
    check("pop_wr_data_out", data_out, 8'h77);
    idle(5 * 41 + 5);
    check("pop_wr_overflow_end", {7'd0, overflow}, 8'h00);
    check("pop_wr_empty_end", {7'd0, empty}, 8'h01);

    // Reset in data bit 3 of 0x5A with a second byte still queued.
    drive(1'b1, 1'b1, 8'h5A);
    drive(1'b1, 1'b1, 8'h99);
    repeat (15) drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("mid_bit2_tx", {7'd0, tx}, 8'h00);
    check("mid_bit2_busy", {7'd0, busy}, 8'h01);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check("mid_rst_tx", {7'd0, tx}, 8'h01);
    check("mid_rst_busy", {7'd0, busy}, 8'h00);
    check("mid_rst_empty", {7'd0, empty}, 8'h01);
    drive(1'b1, 1'b1, 8'hC3);
    drive(1'b1, 1'b0, 8'h00);
    idle(45);
    check("c3_data_out", data_out, 8'hC3);

    // Pin the model's transmitted stream to the hand-derived order.
    check("stream_len", 8'(sent_q.size()), 8'd17);
    for (int i = 0; i < 17; i++) begin
      check($sformatf("stream_%0d", i), (i < sent_q.size()) ? sent_q[i] : 8'hxx, exp_stream[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
